// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2), decode (T3), ALU execute (T4),
// write-back (T5), plus an absorbing HALT state left only through clear.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] register_select,
  output logic        Z_LO_select,
  output logic        PC_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic [15:0] reg_in,
  output logic        MAR_in,
  output logic        PC_in,
  output logic        IR_in,
  output logic        MDR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic [3:0]  alu_op,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    T0   = 3'b000,
    T1   = 3'b001,
    T2   = 3'b010,
    T3   = 3'b011,
    T4   = 3'b100,
    T5   = 3'b101,
    HALT = 3'b110
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     cur;
  state_t     nxt;
  logic       t1_wait;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       r_type;
  logic       i_type;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign state     = cur;

  function automatic logic is_r_type(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_i_type(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:          return 4'b0001;
      OP_AND, OP_ANDI: return 4'b0010;
      OP_OR,  OP_ORI:  return 4'b0011;
      default:         return 4'b0000;
    endcase
  endfunction

  assign r_type = is_r_type(opcode);
  assign i_type = is_i_type(opcode);

  // t1_wait marks every T1 cycle after the first, so PC is loaded only once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur     <= T0;
      t1_wait <= 1'b0;
    end else begin
      cur     <= nxt;
      t1_wait <= (cur == T1) && !mem_ready;
    end
  end

  always_comb begin
    nxt             = cur;
    register_select = '0;
    Z_LO_select     = 1'b0;
    PC_select       = 1'b0;
    MDR_select      = 1'b0;
    c_select        = 1'b0;
    reg_in          = '0;
    MAR_in          = 1'b0;
    PC_in           = 1'b0;
    IR_in           = 1'b0;
    MDR_in          = 1'b0;
    Y_in            = 1'b0;
    Z_in            = 1'b0;
    inc_pc          = 1'b0;
    mem_read        = 1'b0;
    alu_op          = 4'b0000;
    halted          = 1'b0;

    case (cur)
      T0:      if (run) nxt = T1;
      T1:      if (mem_ready) nxt = T2;
      T2:      nxt = T3;
      T3: begin
        if (r_type || i_type)      nxt = T4;
        else if (opcode == OP_HALT) nxt = HALT;
        else                        nxt = T0;
      end
      T4:      nxt = (r_type || i_type) ? T5 : T0;
      T5:      nxt = T0;
      HALT:    nxt = HALT;
      default: nxt = T0;
    endcase

    // Strobes are held low for as long as clear is asserted.
    if (clear) begin
      case (cur)
        T0: if (run) begin
          PC_select = 1'b1;
          MAR_in    = 1'b1;
          inc_pc    = 1'b1;
          Z_in      = 1'b1;
          alu_op    = 4'b1111;
        end
        T1: begin
          Z_LO_select = 1'b1;
          PC_in       = !t1_wait;
          mem_read    = 1'b1;
          MDR_in      = 1'b1;
        end
        T2: begin
          MDR_select = 1'b1;
          IR_in      = 1'b1;
        end
        T3: if (r_type || i_type) begin
          register_select = 16'd1 << rb;
          Y_in            = 1'b1;
        end
        T4: if (r_type || i_type) begin
          if (r_type) register_select = 16'd1 << rc;
          else        c_select        = 1'b1;
          Z_in   = 1'b1;
          alu_op = alu_code(opcode);
        end
        T5: begin
          Z_LO_select = 1'b1;
          reg_in      = 16'd1 << ra;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instructions through every state
// and checks all strobes against hand-decoded values.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
  logic [15:0] register_select;
  logic        Z_LO_select, PC_select, MDR_select, c_select;
  logic [15:0] reg_in;
  logic        MAR_in, PC_in, IR_in, MDR_in, Y_in, Z_in, inc_pc, mem_read;
  logic [3:0]  alu_op;
  logic        halted;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  // Field layout: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
  localparam logic [31:0] IR_ADD  = 32'h1989_0000; // add  R3,R1,R2
  localparam logic [31:0] IR_SUB  = 32'h2238_0000; // sub  R4,R7,R0
  localparam logic [31:0] IR_ORI  = 32'h5290_0000; // ori  R5,R2
  localparam logic [31:0] IR_ANDI = 32'h4878_0000; // andi R0,R15
  localparam logic [31:0] IR_NOP  = 32'h0000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .register_select(register_select), .Z_LO_select(Z_LO_select),
    .PC_select(PC_select), .MDR_select(MDR_select), .c_select(c_select),
    .reg_in(reg_in), .MAR_in(MAR_in), .PC_in(PC_in), .IR_in(IR_in),
    .MDR_in(MDR_in), .Y_in(Y_in), .Z_in(Z_in), .inc_pc(inc_pc),
    .mem_read(mem_read), .alu_op(alu_op), .halted(halted), .state(state)
  );

  logic [19:0] src;
  logic [7:0]  en;
  assign src = {register_select, Z_LO_select, PC_select, MDR_select, c_select};
  assign en  = {MAR_in, PC_in, IR_in, MDR_in, Y_in, Z_in, inc_pc, mem_read};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [19:0] s,
                     input logic [7:0] e, input logic [15:0] rin,
                     input logic [3:0] alu, input logic hlt);
    chk({tag, ".state"},  32'(state),  32'(st));
    chk({tag, ".src"},    32'(src),    32'(s));
    chk({tag, ".en"},     32'(en),     32'(e));
    chk({tag, ".reg_in"}, 32'(reg_in), 32'(rin));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(alu));
    chk({tag, ".halted"}, 32'(halted), 32'(hlt));
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic fetch_t2(input string tag);
    step(); cyc({tag, ".T1"}, 3'd1, 20'h00008, 8'h51, 16'h0, 4'h0, 1'b0);
    step(); cyc({tag, ".T2"}, 3'd2, 20'h00002, 8'h20, 16'h0, 4'h0, 1'b0);
  endtask

  always @(negedge clock) begin
    checks++;
    assert (($countones(src) <= 1) && ($countones(reg_in) <= 1) &&
            (reg_in == 16'h0 || state == 3'd5)) else begin
      failures++;
      $error("FAIL onehot observed src=%0h reg_in=%0h state=%0d expected at most one strobe",
             src, reg_in, state);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = IR_ADD;
    #12;
    cyc("rst", 3'd0, 20'h0, 8'h00, 16'h0, 4'h0, 1'b0);
    step();
    cyc("rst_clk", 3'd0, 20'h0, 8'h00, 16'h0, 4'h0, 1'b0);

    // add: full pass, run dropped after leaving T0
    @(negedge clock); clear = 1'b1; #1;
    cyc("add.T0", 3'd0, 20'h00004, 8'h86, 16'h0, 4'hF, 1'b0);
    step(); cyc("add.T1", 3'd1, 20'h00008, 8'h51, 16'h0, 4'h0, 1'b0);
    run = 1'b0;
    step(); cyc("add.T2", 3'd2, 20'h00002, 8'h20, 16'h0, 4'h0, 1'b0);
    step(); cyc("add.T3", 3'd3, 20'h00020, 8'h08, 16'h0, 4'h0, 1'b0);
    step(); cyc("add.T4", 3'd4, 20'h00040, 8'h04, 16'h0, 4'h0, 1'b0);
    step(); cyc("add.T5", 3'd5, 20'h00008, 8'h00, 16'h0008, 4'h0, 1'b0);
    step(); cyc("idle0", 3'd0, 20'h0, 8'h00, 16'h0, 4'h0, 1'b0);
    step(); cyc("idle1", 3'd0, 20'h0, 8'h00, 16'h0, 4'h0, 1'b0);
    run = 1'b1; ir = IR_SUB; #1;
    cyc("sub.T0", 3'd0, 20'h00004, 8'h86, 16'h0, 4'hF, 1'b0);

    // sub: ir garbage during fetch must not matter
    step(); cyc("sub.T1", 3'd1, 20'h00008, 8'h51, 16'h0, 4'h0, 1'b0);
    ir = IR_HALT;
    step(); cyc("sub.T2", 3'd2, 20'h00002, 8'h20, 16'h0, 4'h0, 1'b0);
    ir = IR_SUB;
    step(); cyc("sub.T3", 3'd3, 20'h00800, 8'h08, 16'h0, 4'h0, 1'b0);
    step(); cyc("sub.T4", 3'd4, 20'h00010, 8'h04, 16'h0, 4'h1, 1'b0);
    step(); cyc("sub.T5", 3'd5, 20'h00008, 8'h00, 16'h0010, 4'h0, 1'b0);

    // ori with a 3-cycle memory stall
    step(); cyc("ori.T0", 3'd0, 20'h00004, 8'h86, 16'h0, 4'hF, 1'b0);
    ir = IR_ORI; mem_ready = 1'b0;
    step(); cyc("ori.T1a", 3'd1, 20'h00008, 8'h51, 16'h0, 4'h0, 1'b0);
    step(); cyc("ori.T1b", 3'd1, 20'h00008, 8'h11, 16'h0, 4'h0, 1'b0);
    step(); cyc("ori.T1c", 3'd1, 20'h00008, 8'h11, 16'h0, 4'h0, 1'b0);
    step(); cyc("ori.T1d", 3'd1, 20'h00008, 8'h11, 16'h0, 4'h0, 1'b0);
    mem_ready = 1'b1;
    step(); cyc("ori.T2", 3'd2, 20'h00002, 8'h20, 16'h0, 4'h0, 1'b0);
    step(); cyc("ori.T3", 3'd3, 20'h00040, 8'h08, 16'h0, 4'h0, 1'b0);
    step(); cyc("ori.T4", 3'd4, 20'h00001, 8'h04, 16'h0, 4'h3, 1'b0);
    step(); cyc("ori.T5", 3'd5, 20'h00008, 8'h00, 16'h0020, 4'h0, 1'b0);

    // andi writing R0 from R15
    step(); ir = IR_ANDI;
    fetch_t2("andi");
    step(); cyc("andi.T3", 3'd3, 20'h80000, 8'h08, 16'h0, 4'h0, 1'b0);
    step(); cyc("andi.T4", 3'd4, 20'h00001, 8'h04, 16'h0, 4'h2, 1'b0);
    step(); cyc("andi.T5", 3'd5, 20'h00008, 8'h00, 16'h0001, 4'h0, 1'b0);

    // nop returns to T0 straight from decode
    step(); ir = IR_NOP;
    fetch_t2("nop");
    step(); cyc("nop.T3", 3'd3, 20'h0, 8'h00, 16'h0, 4'h0, 1'b0);
    step(); cyc("nop.T0", 3'd0, 20'h00004, 8'h86, 16'h0, 4'hF, 1'b0);

    // halt is absorbing regardless of run
    ir = IR_HALT;
    fetch_t2("halt");
    step(); cyc("halt.T3", 3'd3, 20'h0, 8'h00, 16'h0, 4'h0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step();
      cyc("halt.hold", 3'd6, 20'h0, 8'h00, 16'h0, 4'h0, 1'b1);
      run = ~run;
    end
    #1 clear = 1'b0;
    #1 cyc("halt.clr", 3'd0, 20'h0, 8'h00, 16'h0, 4'h0, 1'b0);
    @(negedge clock); clear = 1'b1; run = 1'b1; ir = IR_ADD; #1;
    cyc("rel.T0", 3'd0, 20'h00004, 8'h86, 16'h0, 4'hF, 1'b0);

    // asynchronous clear in T4
    fetch_t2("async");
    step(); cyc("async.T3", 3'd3, 20'h00020, 8'h08, 16'h0, 4'h0, 1'b0);
    step(); cyc("async.T4", 3'd4, 20'h00040, 8'h04, 16'h0, 4'h0, 1'b0);
    #1 clear = 1'b0;
    #1 cyc("async.clr", 3'd0, 20'h0, 8'h00, 16'h0, 4'h0, 1'b0);
    @(negedge clock); clear = 1'b1; #1;
    cyc("async.T0", 3'd0, 20'h00004, 8'h86, 16'h0, 4'hF, 1'b0);
    step(); cyc("async.T1", 3'd1, 20'h00008, 8'h51, 16'h0, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
